// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared types and golden function for the two-input gate response checker
package gate_chk_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

    typedef logic [1:0] vec_t;

    // {in1,in2} -> {exp1,exp2}; exp1 reduces to in1|in2 but is kept in the gate's own form
    function automatic vec_t gate_expected(input vec_t v);
        return {((v[1] & v[0]) ^ v[1]) | v[0], ~v[0]};
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// gate_golden_model: combinational expected response for one applied vector, swappable per DUT
import gate_chk_pkg::*;

module gate_golden_model (
    input  logic [1:0] vec,
    output logic [1:0] expected
);

    assign expected = gate_expected(vec);

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: accepts vectors, waits a settle interval, compares DUT outputs and keeps statistics; CHK_FIRST_FAIL_EN enables first-mismatch capture
import gate_chk_pkg::*;

module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    input  logic             vec_in1,
    input  logic             vec_in2,
    input  logic             dut_out1,
    input  logic             dut_out2,
    input  logic             clr,
    output logic             ready,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic [1:0]       first_fail_vec,
    output logic [1:0]       first_fail_got
);

    localparam logic [7:0]       SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    vec_t       vec, expected;
    logic       sample, match;

    assign ready  = (state == IDLE);
    assign sample = (state == SAMPLE);
    assign match  = ({dut_out1, dut_out2} == expected);

    gate_golden_model u_golden (
        .vec      (vec),
        .expected (expected)
    );

    // next state: accept in IDLE, count down the settle interval, sample for one cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (vec_valid) begin
                    state_nx = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                state_nx = (cnt == 8'd0) ? SAMPLE : SETTLE;
                cnt_nx   = (cnt == 8'd0) ? cnt : cnt - 8'd1;
            end
            SAMPLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register and latched vector; reset discards any in-flight vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            vec   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (vec_valid && ready) vec <= {vec_in1, vec_in2};
        end
    end

    // one-cycle result pulse; clr leaves the reported result untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
        end else begin
            chk_valid <= sample;
            if (sample) chk_pass <= match;
        end
    end

    // saturating statistics; clr beats a coincident comparison
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
        end else if (sample) begin
            if (match) begin
                pass_cnt <= (pass_cnt == CNT_MAX) ? pass_cnt : pass_cnt + 1'b1;
            end else begin
                fail_cnt   <= (fail_cnt == CNT_MAX) ? fail_cnt : fail_cnt + 1'b1;
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef CHK_FIRST_FAIL_EN
    // capture only the first mismatch since reset/clr, i.e. while err_sticky is still clear
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            first_fail_vec <= '0;
            first_fail_got <= '0;
        end else if (sample && !match && !err_sticky) begin
            first_fail_vec <= vec;
            first_fail_got <= {dut_out1, dut_out2};
        end
    end
`else
    assign first_fail_vec = '0;
    assign first_fail_got = '0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: scoreboard bench with a behavioural gate DUT (optional out1 stuck-at-0)
module tb_gate_response_checker;

    localparam int S = 2;
    localparam int W = 3;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0, rst_n = 1'b0, vec_valid = 1'b0, vec_in1 = 1'b0, vec_in2 = 1'b0, clr = 1'b0;
    logic         stuck = 1'b0;
    logic         dut_out1, dut_out2, ready, chk_valid, chk_pass, err_sticky;
    logic [W-1:0] pass_cnt, fail_cnt;
    logic [1:0]   first_fail_vec, first_fail_got;
    logic [1:0]   applied = 2'b00;
    logic         clr_e = 1'b0, rst_e = 1'b0;

    typedef struct {logic pass; logic [1:0] v; logic [1:0] g;} exp_t;
    exp_t q[$];

    int vecs = 0, errs = 0, cyc = 0;
    int mp = 0, mf = 0, pulses = 0, last_cyc = -1;
    logic ms = 1'b0;
    logic [1:0] mfv = 2'b00, mfg = 2'b00;
    bit chk_space = 0;

    gate_response_checker #(.SETTLE_CYCLES(S), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_in1(vec_in1), .vec_in2(vec_in2),
        .dut_out1(dut_out1), .dut_out2(dut_out2), .clr(clr), .ready(ready),
        .chk_valid(chk_valid), .chk_pass(chk_pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .err_sticky(err_sticky), .first_fail_vec(first_fail_vec), .first_fail_got(first_fail_got)
    );

    always #5 clk = ~clk;

    // gate under test: out1 = in1|in2, out2 = ~in2, with optional stuck-at-0 on out1
    assign dut_out1 = stuck ? 1'b0 : (applied[1] | applied[0]);
    assign dut_out2 = ~applied[0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // stimulus side of the scoreboard: every accepted vector pushes its expected outcome
    always @(posedge clk) begin
        logic [1:0] v, g;
        cyc   <= cyc + 1;
        clr_e <= clr && rst_n;
        rst_e <= !rst_n;
        if (rst_n && vec_valid && ready) begin
            v = {vec_in1, vec_in2};
            g = {stuck ? 1'b0 : (v[1] | v[0]), ~v[0]};
            q.push_back('{g == {v[1] | v[0], ~v[0]}, v, g});
            applied <= v;
        end
    end

    // monitor: pop and compare on every result pulse, tracking counter model
    always @(negedge clk) begin
        exp_t e;
        if (rst_e) begin
            mp = 0; mf = 0; ms = 1'b0; mfv = 2'b00; mfg = 2'b00;
        end else begin
            if (chk_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_chk_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("chk_pass", chk_pass, e.pass);
                    if (!clr_e) begin
                        if (e.pass) mp = (mp == CMAX) ? mp : mp + 1;
                        else begin
                            mf = (mf == CMAX) ? mf : mf + 1;
                            if (!ms) begin mfv = e.v; mfg = e.g; end
                            ms = 1'b1;
                        end
                    end
                    if (chk_space) begin
                        pulses++;
                        if (last_cyc >= 0) check("pulse_spacing", cyc - last_cyc, S + 2);
                        last_cyc = cyc;
                    end
                end
            end
            if (clr_e) begin
                mp = 0; mf = 0; ms = 1'b0; mfv = 2'b00; mfg = 2'b00;
            end
            if (chk_valid) begin
                check("pass_cnt", pass_cnt, mp);
                check("fail_cnt", fail_cnt, mf);
                check("err_sticky", err_sticky, ms);
`ifdef CHK_FIRST_FAIL_EN
                check("first_fail_vec", first_fail_vec, mfv);
                check("first_fail_got", first_fail_got, mfg);
`endif
            end
        end
    end

    task automatic apply(input logic [1:0] v);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) check("ready_timeout", 0, 1);
        vec_valid = 1'b1;
        {vec_in1, vec_in2} = v;
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", ready, 1);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_chk_pass", chk_pass, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_ffv", first_fail_vec, 0);
        check("rst_ffg", first_fail_got, 0);

        for (int i = 0; i < 4; i++) apply(2'(i));
        drain();
        check("all_pass_cnt", pass_cnt, 4);
        check("all_fail_cnt", fail_cnt, 0);
        check("all_sticky", err_sticky, 0);

        do_clr();
        stuck = 1'b1;
        apply(2'b01);
        drain();
        check("stuck_fail_cnt", fail_cnt, 1);
        check("stuck_sticky", err_sticky, 1);
        check("stuck_chk_pass", chk_pass, 0);
        apply(2'b11);
        drain();
        check("stuck2_fail_cnt", fail_cnt, 2);
`ifdef CHK_FIRST_FAIL_EN
        check("stuck_ffv", first_fail_vec, 2'b01);
`else
        check("stuck_ffv", first_fail_vec, 2'b00);
`endif
        check("stuck_ffg", first_fail_got, 2'b00);
        stuck = 1'b0;

        do_clr();
        check("clr_fail_cnt", fail_cnt, 0);
        check("clr_sticky", err_sticky, 0);
        check("clr_ffv", first_fail_vec, 0);
        chk_space = 1;
        @(negedge clk);
        vec_valid = 1'b1;
        {vec_in1, vec_in2} = 2'b10;
        repeat (20) @(negedge clk);
        vec_valid = 1'b0;
        drain();
        chk_space = 0;
        check("cont_pulses", pulses, 5);
        check("cont_pass_cnt", pass_cnt, 5);

        do_clr();
        for (int i = 0; i < 8; i++) apply(2'(i));
        drain();
        check("sat_pass_cnt", pass_cnt, CMAX);
        apply(2'b11);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_coinc_chk_valid", chk_valid, 1);
        check("clr_coinc_pass_cnt", pass_cnt, 0);
        drain();

        apply(2'b00);
        drain();
        check("pre_rst_pass_cnt", pass_cnt, 1);
        apply(2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        check("midrst_ready", ready, 1);
        check("midrst_chk_valid", chk_valid, 0);
        check("midrst_pass_cnt", pass_cnt, 0);
        check("midrst_fail_cnt", fail_cnt, 0);
        repeat (6) @(negedge clk);
        check("midrst_no_result", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable response checker for the two-input gate test block: the receiving end of the vector-stimulus interface. It accepts each applied input vector and waits a programmable settle interval matching the DUT output delay. It then samples the DUT outputs, compares them to a built-in golden model and accumulates pass/fail statistics. It sits beside the DUT in on-FPGA self-test, replacing waveform inspection.

## Interface
- SETTLE_CYCLES, 2, cycles waited after vector acceptance before sampling; legal range 0..255
- CNT_W, 8, width of pass/fail counters
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- vec_valid  input  1  stimulus presents a new vector this cycle
- vec_in1, vec_in2  input  1 each  vector bits as applied to DUT in1/in2
- dut_out1, dut_out2  input  1 each  DUT responses
- clr  input  1  synchronous clear of counters and sticky/capture state
- ready  output  1  checker can accept a vector
- chk_valid  output  1  one-cycle pulse: comparison result is valid
- chk_pass  output  1  result of the most recent comparison, 1 = match
- pass_cnt, fail_cnt  output  CNT_W each  saturating match/mismatch counts
- err_sticky  output  1  set on any mismatch until clr/reset
- first_fail_vec  output  2  {in1,in2} of first mismatching vector
- first_fail_got  output  2  {out1,out2} observed on first mismatch

## Operation
- Golden model: exp1 = ((in1 & in2) ^ in1) | in2, which equals in1 | in2; exp2 = ~in2.
- Handshake: a vector is accepted on a rising edge where vec_valid & ready. The vector bits are latched. vec_valid while ready=0 is ignored, not queued.
- FSM states:
  - IDLE: ready=1. On accept, go to SETTLE, or straight to SAMPLE if SETTLE_CYCLES==0.
  - SETTLE: down-counter runs for SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: compare {dut_out1,dut_out2} with the expected value from the latched vector. Register the result, then return to IDLE.
- On each comparison:
  - chk_valid pulses and chk_pass is updated.
  - On a match, pass_cnt increments. On a mismatch, fail_cnt increments and err_sticky is set.
  - Counters saturate at 2^CNT_W-1; no wrap.
- clr: zeroes pass_cnt, fail_cnt, err_sticky and the capture registers. clr does not disturb the FSM.
  - If clr and a comparison land on the same edge, clr wins. The counters read 0, but chk_valid/chk_pass still report that comparison.
- Reset values: ready=1 (IDLE). chk_valid, chk_pass, counters, err_sticky, first_fail_vec and first_fail_got are all 0.
- rst_n low in any state returns the FSM to IDLE on that edge. An in-flight vector is discarded and produces no chk_valid.

## Timing
- Accept on edge E0. chk_valid, chk_pass and the counters update at edge E0+SETTLE_CYCLES+1. chk_valid is high for exactly one cycle.
- ready is low from E0 until the chk_valid edge, and high in the chk_valid cycle. The next vector can therefore be accepted on edge E0+SETTLE_CYCLES+2.
- Throughput: one vector per SETTLE_CYCLES+2 cycles.
- dut_out* are sampled only in the SAMPLE cycle. The inputs are treated as synchronous to clk.

## Configuration
- CHK_FIRST_FAIL_EN defined: on the first mismatch after reset/clr (err_sticky was 0), capture first_fail_vec and first_fail_got. Later mismatches leave them unchanged.
- CHK_FIRST_FAIL_EN undefined: no capture registers are built; first_fail_vec and first_fail_got are tied to 0. All other behaviour is identical.

## Structure
- Package gate_chk_pkg contains:
  - state enum {IDLE, SETTLE, SAMPLE}
  - 2-bit vector typedef
  - golden function gate_expected(vec) returning {exp1,exp2}
- One sub-module, gate_golden_model: purely combinational, 2-bit vector in, 2-bit expected out. It is instanced once, so the model can be swapped per DUT.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> ready=1, chk_valid=0, pass_cnt=fail_cnt=0, err_sticky=0, first_fail_*=0.
- Correct DUT, SETTLE_CYCLES=2, vectors 00,01,10,11 -> 4 chk_valid pulses with chk_pass=1; pass_cnt=4, fail_cnt=0, err_sticky=0.
- DUT out1 stuck at 0, vector {in1,in2}=01 -> chk_pass=0, fail_cnt=1, err_sticky=1. With CHK_FIRST_FAIL_EN: first_fail_vec=01, first_fail_got=00.
- vec_valid held high continuously with SETTLE_CYCLES=2 -> acceptances every 4 cycles; chk_valid pulses spaced exactly 4 cycles apart; no vectors are double-counted.
- CNT_W=2, 5 matching vectors -> pass_cnt saturates at 3. clr coincident with the 5th result -> pass_cnt=0, chk_valid still pulses.
- rst_n low during SETTLE -> next cycle: FSM in IDLE, ready=1, no chk_valid, all counters 0.
